mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 clock  in  1  single clock; all state updates on posedge clock.
REQ-002 reset  in  1  asynchronous, active-high; clears all registered outputs immediately.
REQ-003 EX_MEM_LS_bit  in  2  access size: 00 word, 01 byte, 10 halfword, 11 treated as word.
REQ-004 EX_MEM_Branch  in  2  00 none, 01 beq (take if zero=1), 10 bne (take if zero=0), 11 none.
REQ-005 EX_MEM_MemtoReg, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_PctoReg  in  1 each  control bits from EX_MEM.
REQ-006 EX_MEM_Jump, EX_MEM_Ext_op  in  1 each  jump request; load extension (1 sign, 0 zero).
REQ-007 EX_MEM_branch_add_out, EX_MEM_pc_add_out  in  32 each  branch target; PC+4 of the instruction.
REQ-008 EX_MEM_zero  in  1  ALU zero flag.
REQ-009 EX_MEM_instr26  in  26  jump index field.
REQ-010 EX_MEM_alu_out  in  32  data address / ALU result.
REQ-011 EX_MEM_regfile_out2  in  32  store data.
REQ-012 EX_MEM_mux1_out  in  5  destination register number.
REQ-013 pc_redirect  out  1  combinational: taken branch or jump this cycle.
REQ-014 redirect_target  out  32  combinational next-PC when pc_redirect=1, else 0.
REQ-015 flush  out  1  registered; high for exactly one cycle after a redirect.
REQ-016 MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_PctoReg  out  1 each  registered controls.
REQ-017 MEM_WB_mux1_out  out  5  registered destination register.
REQ-018 MEM_WB_mem_out, MEM_WB_alu_out, MEM_WB_pc_add_out  out  32 each  registered load data, ALU result, PC+4.
REQ-019 MEM_WB_misalign  out  1  registered; misaligned access occurred in the captured instruction.
REQ-020 misalign_count  out  8  saturating count of misaligned accesses since reset.

Function
REQ-021 Data memory: 1024 x 32-bit words, index EX_MEM_alu_out[11:2]; read combinational; write at posedge clock.
REQ-022 Misaligned: halfword with alu_out[0]=1, or word with alu_out[1:0]!=00; byte never misaligned.
REQ-023 Word store writes all 32 bits; halfword store writes [15:0] if alu_out[1]=0 else [31:16]; byte store writes lane alu_out[1:0] (lane k = bits 8k+7..8k); other bits unchanged.
REQ-024 Misaligned store: memory not written; misalign flagged.
REQ-025 Load: select the same lane as REQ-023, extend to 32 bits per Ext_op; word load ignores Ext_op.
REQ-026 Misaligned load: MEM_WB_mem_out=0, MEM_WB_RegWrite=0, misalign flagged.
REQ-027 MEM_WB_misalign=1 only when misaligned and (MemWrite=1 or MemtoReg=1); non-memory instructions never flag.
REQ-028 misalign_count increments by 1 per flagged cycle; holds at 8'hFF.
REQ-029 Jump has priority over branch; jump target = {EX_MEM_pc_add_out[31:28], instr26, 2'b00}; branch target = EX_MEM_branch_add_out.
REQ-030 flush <= pc_redirect each posedge; back-to-back redirects keep flush high.
REQ-031 Latency: all MEM_WB_* outputs reflect EX_MEM inputs one posedge later; no stall, every cycle captures.
REQ-032 Store and load address equal in same cycle: store issued that cycle is not visible to its own read.

Reset
REQ-033 While reset=1: MEM_WB_RegWrite/MemtoReg/PctoReg/misalign=0, flush=0, MEM_WB_mux1_out=0, MEM_WB_mem_out=0, MEM_WB_alu_out=0, MEM_WB_pc_add_out=32'h0000_3004, misalign_count=0; memory writes suppressed; memory contents not cleared.
REQ-034 Reset asserted mid-operation discards the in-flight capture; first capture after release is at the first posedge with reset=0.

Verification
REQ-035 Word store 32'hDEADBEEF at 0x10, then word load 0x10 -> MEM_WB_mem_out=32'hDEADBEEF one cycle after load.
REQ-036 Byte loads at 0x11 of that word, Ext_op=1 then 0 -> 32'hFFFFFFBE then 32'h000000BE; byte store 8'h12 at 0x13 -> word reads 32'h12ADBEEF.
REQ-037 Halfword load at 0x11 with RegWrite=1 -> MEM_WB_mem_out=0, MEM_WB_RegWrite=0, MEM_WB_misalign=1, misalign_count 0->1.
REQ-038 Branch=01 zero=1 with Jump=1, pc_add_out=32'h0000_3010, instr26=26'h0000C10 -> pc_redirect=1, redirect_target=32'h0000_3040, flush=1 next cycle only.
REQ-039 Branch=10 zero=1, Jump=0 -> pc_redirect=0, redirect_target=0; Branch=11 -> no redirect.
REQ-040 Reset pulse after 300 misaligned accesses -> misalign_count=0 (saturated at 8'hFF before reset), MEM_WB_pc_add_out=32'h0000_3004 without clock edge, previously stored word still readable.

Source files
------------

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage with byte-lane data memory and the MEM/WB pipeline register.
// Also resolves branch/jump redirects and counts misaligned memory accesses.
module mem_wb_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  EX_MEM_LS_bit,
    input  logic [1:0]  EX_MEM_Branch,
    input  logic        EX_MEM_MemtoReg,
    input  logic        EX_MEM_MemWrite,
    input  logic        EX_MEM_RegWrite,
    input  logic        EX_MEM_PctoReg,
    input  logic        EX_MEM_Jump,
    input  logic        EX_MEM_Ext_op,
    input  logic [31:0] EX_MEM_branch_add_out,
    input  logic [31:0] EX_MEM_pc_add_out,
    input  logic        EX_MEM_zero,
    input  logic [25:0] EX_MEM_instr26,
    input  logic [31:0] EX_MEM_alu_out,
    input  logic [31:0] EX_MEM_regfile_out2,
    input  logic [4:0]  EX_MEM_mux1_out,
    output logic        pc_redirect,
    output logic [31:0] redirect_target,
    output logic        flush,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_MemtoReg,
    output logic        MEM_WB_PctoReg,
    output logic [4:0]  MEM_WB_mux1_out,
    output logic [31:0] MEM_WB_mem_out,
    output logic [31:0] MEM_WB_alu_out,
    output logic [31:0] MEM_WB_pc_add_out,
    output logic        MEM_WB_misalign,
    output logic [7:0]  misalign_count
);

    logic [31:0] mem_q [0:1023];

    logic [9:0]  idx;
    logic [1:0]  lane;
    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic        flag_d;
    logic [31:0] rdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_d;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic        branch_taken;

    logic        flush_q;
    logic        regwrite_q;
    logic        memtoreg_q;
    logic        pctoreg_q;
    logic [4:0]  rd_q;
    logic [31:0] mem_out_q;
    logic [31:0] alu_q;
    logic [31:0] pc_q;
    logic        misalign_q;
    logic [7:0]  count_q;

    always_comb begin
        idx        = EX_MEM_alu_out[11:2];
        lane       = EX_MEM_alu_out[1:0];
        is_byte    = (EX_MEM_LS_bit == 2'b01);
        is_half    = (EX_MEM_LS_bit == 2'b10);
        misaligned = is_half ? lane[0] : (is_byte ? 1'b0 : (lane != 2'b00));
        flag_d     = misaligned & (EX_MEM_MemWrite | EX_MEM_MemtoReg);

        // Read sees the pre-write contents, so a same-cycle store is invisible here.
        rdata   = mem_q[idx];
        ld_byte = rdata[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? rdata[31:16] : rdata[15:0];
        if (misaligned)
            load_d = 32'h0;
        else if (is_byte)
            load_d = {{24{EX_MEM_Ext_op & ld_byte[7]}}, ld_byte};
        else if (is_half)
            load_d = {{16{EX_MEM_Ext_op & ld_half[15]}}, ld_half};
        else
            load_d = rdata;

        if (is_byte) begin
            wdata = {4{EX_MEM_regfile_out2[7:0]}};
            be    = 4'b0001 << lane;
        end else if (is_half) begin
            wdata = {2{EX_MEM_regfile_out2[15:0]}};
            be    = lane[1] ? 4'b1100 : 4'b0011;
        end else begin
            wdata = EX_MEM_regfile_out2;
            be    = 4'b1111;
        end
        we = EX_MEM_MemWrite & ~misaligned & ~reset;
    end

    always_comb begin
        branch_taken = ((EX_MEM_Branch == 2'b01) &  EX_MEM_zero) |
                       ((EX_MEM_Branch == 2'b10) & ~EX_MEM_zero);
        pc_redirect  = EX_MEM_Jump | branch_taken;
        if (EX_MEM_Jump)
            redirect_target = {EX_MEM_pc_add_out[31:28], EX_MEM_instr26, 2'b00};
        else if (branch_taken)
            redirect_target = EX_MEM_branch_add_out;
        else
            redirect_target = 32'h0;
    end

    // Memory has no reset: contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k])
                    mem_q[idx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flush_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            pctoreg_q  <= 1'b0;
            rd_q       <= 5'd0;
            mem_out_q  <= 32'h0;
            alu_q      <= 32'h0;
            pc_q       <= 32'h0000_3004;
            misalign_q <= 1'b0;
            count_q    <= 8'h00;
        end else begin
            flush_q    <= pc_redirect;
            regwrite_q <= EX_MEM_RegWrite & ~(misaligned & EX_MEM_MemtoReg);
            memtoreg_q <= EX_MEM_MemtoReg;
            pctoreg_q  <= EX_MEM_PctoReg;
            rd_q       <= EX_MEM_mux1_out;
            mem_out_q  <= load_d;
            alu_q      <= EX_MEM_alu_out;
            pc_q       <= EX_MEM_pc_add_out;
            misalign_q <= flag_d;
            if (flag_d && count_q != 8'hFF)
                count_q <= count_q + 8'd1;
        end
    end

    assign flush             = flush_q;
    assign MEM_WB_RegWrite   = regwrite_q;
    assign MEM_WB_MemtoReg   = memtoreg_q;
    assign MEM_WB_PctoReg    = pctoreg_q;
    assign MEM_WB_mux1_out   = rd_q;
    assign MEM_WB_mem_out    = mem_out_q;
    assign MEM_WB_alu_out    = alu_q;
    assign MEM_WB_pc_add_out = pc_q;
    assign MEM_WB_misalign   = misalign_q;
    assign misalign_count    = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  EX_MEM_LS_bit;
    logic [1:0]  EX_MEM_Branch;
    logic        EX_MEM_MemtoReg;
    logic        EX_MEM_MemWrite;
    logic        EX_MEM_RegWrite;
    logic        EX_MEM_PctoReg;
    logic        EX_MEM_Jump;
    logic        EX_MEM_Ext_op;
    logic [31:0] EX_MEM_branch_add_out;
    logic [31:0] EX_MEM_pc_add_out;
    logic        EX_MEM_zero;
    logic [25:0] EX_MEM_instr26;
    logic [31:0] EX_MEM_alu_out;
    logic [31:0] EX_MEM_regfile_out2;
    logic [4:0]  EX_MEM_mux1_out;
    logic        pc_redirect;
    logic [31:0] redirect_target;
    logic        flush;
    logic        MEM_WB_RegWrite;
    logic        MEM_WB_MemtoReg;
    logic        MEM_WB_PctoReg;
    logic [4:0]  MEM_WB_mux1_out;
    logic [31:0] MEM_WB_mem_out;
    logic [31:0] MEM_WB_alu_out;
    logic [31:0] MEM_WB_pc_add_out;
    logic        MEM_WB_misalign;
    logic [7:0]  misalign_count;

    mem_wb_stage dut (
        .clock(clock), .reset(reset),
        .EX_MEM_LS_bit(EX_MEM_LS_bit), .EX_MEM_Branch(EX_MEM_Branch),
        .EX_MEM_MemtoReg(EX_MEM_MemtoReg), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_PctoReg(EX_MEM_PctoReg),
        .EX_MEM_Jump(EX_MEM_Jump), .EX_MEM_Ext_op(EX_MEM_Ext_op),
        .EX_MEM_branch_add_out(EX_MEM_branch_add_out), .EX_MEM_pc_add_out(EX_MEM_pc_add_out),
        .EX_MEM_zero(EX_MEM_zero), .EX_MEM_instr26(EX_MEM_instr26),
        .EX_MEM_alu_out(EX_MEM_alu_out), .EX_MEM_regfile_out2(EX_MEM_regfile_out2),
        .EX_MEM_mux1_out(EX_MEM_mux1_out),
        .pc_redirect(pc_redirect), .redirect_target(redirect_target), .flush(flush),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_MemtoReg(MEM_WB_MemtoReg),
        .MEM_WB_PctoReg(MEM_WB_PctoReg), .MEM_WB_mux1_out(MEM_WB_mux1_out),
        .MEM_WB_mem_out(MEM_WB_mem_out), .MEM_WB_alu_out(MEM_WB_alu_out),
        .MEM_WB_pc_add_out(MEM_WB_pc_add_out), .MEM_WB_misalign(MEM_WB_misalign),
        .misalign_count(misalign_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;
    logic [31:0] pc_ctr = 32'h0000_3100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-addressed model memory with per-byte "written" tracking.
    logic [7:0] mb [0:4095];
    bit         mv [0:4095];

    logic        e_rw, e_mtr, e_p2r, e_mis, e_flush, e_known;
    logic [4:0]  e_rd;
    logic [31:0] e_mem, e_alu, e_pc;
    logic [7:0]  e_cnt;

    function automatic logic [32:0] model_redirect();
        bit take;
        take = (EX_MEM_Branch == 2'd1 && EX_MEM_zero) || (EX_MEM_Branch == 2'd2 && !EX_MEM_zero);
        if (EX_MEM_Jump)
            return {1'b1, EX_MEM_pc_add_out[31:28], EX_MEM_instr26, 2'b00};
        if (take)
            return {1'b1, EX_MEM_branch_add_out};
        return 33'h0;
    endfunction

    always @(posedge clock or posedge reset) begin
        int          sz;
        int          a;
        bit          mis;
        bit          known;
        logic [31:0] v;
        logic [32:0] rd;
        if (reset) begin
            e_rw = 0; e_mtr = 0; e_p2r = 0; e_mis = 0; e_flush = 0;
            e_rd = 0; e_mem = 0; e_known = 1; e_alu = 0; e_pc = 32'h0000_3004; e_cnt = 0;
        end else begin
            a   = int'(EX_MEM_alu_out[11:0]);
            sz  = (EX_MEM_LS_bit == 2'd1) ? 1 : ((EX_MEM_LS_bit == 2'd2) ? 2 : 4);
            mis = (a % sz) != 0;
            v = 0; known = 1;
            if (!mis) begin
                for (int i = 0; i < sz; i++) begin
                    if (!mv[a+i]) known = 0;
                    v = v | (32'(mb[a+i]) << (8*i));
                end
                if (sz == 1 && EX_MEM_Ext_op && v[7])  v = v | 32'hFFFF_FF00;
                if (sz == 2 && EX_MEM_Ext_op && v[15]) v = v | 32'hFFFF_0000;
            end
            rd = model_redirect();
            e_mem = v; e_known = known;
            e_rw  = EX_MEM_RegWrite && !(mis && EX_MEM_MemtoReg);
            e_mtr = EX_MEM_MemtoReg; e_p2r = EX_MEM_PctoReg; e_rd = EX_MEM_mux1_out;
            e_alu = EX_MEM_alu_out; e_pc = EX_MEM_pc_add_out; e_flush = rd[32];
            e_mis = mis && (EX_MEM_MemWrite || EX_MEM_MemtoReg);
            if (e_mis && e_cnt != 8'hFF) e_cnt = e_cnt + 1;
            if (EX_MEM_MemWrite && !mis) begin
                for (int i = 0; i < sz; i++) begin
                    mb[a+i] = 8'(EX_MEM_regfile_out2 >> (8*i));
                    mv[a+i] = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [32:0] rd;
        if (chk_en) begin
            rd = model_redirect();
            check("pc_redirect", 32'(pc_redirect), 32'(rd[32]));
            check("redirect_target", redirect_target, rd[31:0]);
            check("flush", 32'(flush), 32'(e_flush));
            check("RegWrite", 32'(MEM_WB_RegWrite), 32'(e_rw));
            check("MemtoReg", 32'(MEM_WB_MemtoReg), 32'(e_mtr));
            check("PctoReg", 32'(MEM_WB_PctoReg), 32'(e_p2r));
            check("mux1_out", 32'(MEM_WB_mux1_out), 32'(e_rd));
            check("alu_out", MEM_WB_alu_out, e_alu);
            check("pc_add_out", MEM_WB_pc_add_out, e_pc);
            check("misalign", 32'(MEM_WB_misalign), 32'(e_mis));
            check("misalign_count", 32'(misalign_count), 32'(e_cnt));
            if (e_known) check("mem_out", MEM_WB_mem_out, e_mem);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic [1:0] ls, input logic mw, input logic mtr, input logic rw,
                          input logic ext, input logic [31:0] addr, input logic [31:0] data);
        EX_MEM_LS_bit = ls; EX_MEM_MemWrite = mw; EX_MEM_MemtoReg = mtr;
        EX_MEM_RegWrite = rw; EX_MEM_Ext_op = ext; EX_MEM_alu_out = addr;
        EX_MEM_regfile_out2 = data; EX_MEM_Branch = 2'd0; EX_MEM_Jump = 0; EX_MEM_zero = 0;
        pc_ctr = pc_ctr + 4; EX_MEM_pc_add_out = pc_ctr; EX_MEM_PctoReg = pc_ctr[2];
        EX_MEM_mux1_out = addr[4:0] ^ 5'h15;
    endtask

    task automatic op(input logic [1:0] ls, input logic mw, input logic mtr, input logic rw,
                      input logic ext, input logic [31:0] addr, input logic [31:0] data);
        set_op(ls, mw, mtr, rw, ext, addr, data);
        tick();
    endtask

    task automatic set_br(input logic [1:0] b, input logic z, input logic j,
                          input logic [31:0] pc, input logic [25:0] i26, input logic [31:0] badd);
        set_op(2'd0, 0, 0, 0, 0, 32'h0, 32'h0);
        EX_MEM_Branch = b; EX_MEM_zero = z; EX_MEM_Jump = j;
        EX_MEM_pc_add_out = pc; EX_MEM_instr26 = i26; EX_MEM_branch_add_out = badd;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mv[i] = 0;
        EX_MEM_instr26 = 26'h0; EX_MEM_branch_add_out = 32'h0;
        set_op(2'd0, 0, 0, 0, 0, 32'h0, 32'h0);
        reset = 0;
        #1 reset = 1;
        #1;
        chk_en = 1;
        check("reset pc_add_out", MEM_WB_pc_add_out, 32'h0000_3004);
        check("reset misalign_count", 32'(misalign_count), 32'h0);
        check("reset flush", 32'(flush), 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 0;

        op(2'd0, 1, 0, 0, 0, 32'h10, 32'hDEAD_BEEF);
        op(2'd0, 0, 1, 1, 0, 32'h10, 32'h0);
        check("word load 0x10", MEM_WB_mem_out, 32'hDEAD_BEEF);
        op(2'd1, 0, 1, 1, 1, 32'h11, 32'h0);
        check("byte load sext", MEM_WB_mem_out, 32'hFFFF_FFBE);
        op(2'd1, 0, 1, 1, 0, 32'h11, 32'h0);
        check("byte load zext", MEM_WB_mem_out, 32'h0000_00BE);
        op(2'd1, 1, 0, 0, 0, 32'h13, 32'h0000_0012);
        op(2'd0, 0, 1, 1, 0, 32'h10, 32'h0);
        check("word after byte store", MEM_WB_mem_out, 32'h12AD_BEEF);
        op(2'd2, 0, 1, 1, 1, 32'h10, 32'h0);
        check("half load low sext", MEM_WB_mem_out, 32'hFFFF_BEEF);
        op(2'd2, 0, 1, 1, 0, 32'h12, 32'h0);
        check("half load high zext", MEM_WB_mem_out, 32'h0000_12AD);

        op(2'd2, 0, 1, 1, 1, 32'h11, 32'h0);
        check("misaligned load data", MEM_WB_mem_out, 32'h0);
        check("misaligned load RegWrite", 32'(MEM_WB_RegWrite), 32'h0);
        check("misaligned load flag", 32'(MEM_WB_misalign), 32'h1);
        check("misaligned load count", 32'(misalign_count), 32'h1);
        op(2'd0, 0, 0, 1, 0, 32'h13, 32'h0);
        check("non-mem misaligned flag", 32'(MEM_WB_misalign), 32'h0);
        check("non-mem count", 32'(misalign_count), 32'h1);

        op(2'd0, 1, 0, 0, 0, 32'h20, 32'hAAAA_5555);
        op(2'd0, 1, 0, 0, 0, 32'h22, 32'h9999_9999);
        op(2'd2, 1, 0, 0, 0, 32'h22, 32'h0000_1234);
        op(2'd0, 0, 1, 1, 0, 32'h20, 32'h0);
        check("half store upper lane", MEM_WB_mem_out, 32'h1234_5555);
        op(2'd3, 1, 0, 0, 0, 32'h24, 32'hCAFE_F00D);
        op(2'd3, 0, 1, 1, 1, 32'h24, 32'h0);
        check("LS=11 as word", MEM_WB_mem_out, 32'hCAFE_F00D);

        op(2'd0, 1, 0, 0, 0, 32'h30, 32'h2222_2222);
        op(2'd0, 1, 1, 1, 0, 32'h30, 32'h1111_1111);
        check("same-cycle store hidden", MEM_WB_mem_out, 32'h2222_2222);
        op(2'd0, 0, 1, 1, 0, 32'h30, 32'h0);
        check("store visible next cycle", MEM_WB_mem_out, 32'h1111_1111);

        set_br(2'd1, 1, 1, 32'h0000_3010, 26'h0000C10, 32'h0000_5000);
        #1;
        check("jump priority redirect", 32'(pc_redirect), 32'h1);
        check("jump target", redirect_target, 32'h0000_3040);
        tick();
        check("flush after jump", 32'(flush), 32'h1);
        set_br(2'd0, 0, 0, 32'h0000_3014, 26'h0, 32'h0);
        tick();
        check("flush one cycle", 32'(flush), 32'h0);
        set_br(2'd1, 1, 0, 32'h0000_3020, 26'h0, 32'h0000_5000);
        #1;
        check("beq target", redirect_target, 32'h0000_5000);
        tick();
        set_br(2'd2, 0, 0, 32'h0000_3024, 26'h0, 32'h0000_6000);
        #1;
        check("bne taken target", redirect_target, 32'h0000_6000);
        tick();
        check("back-to-back flush", 32'(flush), 32'h1);
        set_br(2'd2, 1, 0, 32'h0000_3028, 26'h0, 32'h0000_7000);
        #1;
        check("bne not taken", 32'(pc_redirect), 32'h0);
        check("bne not taken target", redirect_target, 32'h0);
        tick();
        set_br(2'd3, 1, 0, 32'h0000_302C, 26'h0, 32'h0000_7000);
        #1;
        check("branch=11 no redirect", 32'(pc_redirect), 32'h0);
        tick();
        set_br(2'd3, 0, 0, 32'h0000_3030, 26'h0, 32'h0000_7000);
        tick();

        op(2'd0, 1, 0, 0, 0, 32'h40, 32'h600D_600D);
        for (int i = 0; i < 300; i++) op(2'd2, 0, 1, 1, 1, 32'h11, 32'h0);
        check("count saturated", 32'(misalign_count), 32'hFF);

        reset = 1;
        set_op(2'd0, 1, 0, 0, 0, 32'h40, 32'h0BAD_0BAD);
        #1;
        check("async reset count", 32'(misalign_count), 32'h0);
        check("async reset pc", MEM_WB_pc_add_out, 32'h0000_3004);
        check("async reset mem_out", MEM_WB_mem_out, 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 0;
        op(2'd0, 0, 1, 1, 0, 32'h40, 32'h0);
        check("store suppressed in reset", MEM_WB_mem_out, 32'h600D_600D);
        op(2'd0, 0, 1, 1, 0, 32'h10, 32'h0);
        check("memory kept over reset", MEM_WB_mem_out, 32'h12AD_BEEF);
        check("count after reset", 32'(misalign_count), 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
